can_tx_mailbox: RTL and testbench

CAN_TX_MAILBOX -- requirements
Module: can_tx_mailbox

---
 rtl/can_tx_mailbox.sv | 226 ++++++++++++++++++++++
 tb/tb_can_tx_mailbox.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/can_tx_mailbox.sv
// CAN transmit mailbox bank: APB-programmed frames, lowest-ID arbitration,
// retry/abort bookkeeping and cancel handling toward the protocol core.
module can_tx_mailbox #(
   parameter int NUM_MB      = 8,
   parameter int RETRY_LIMIT = 3,
   parameter int APB_AW      = 12
) (
   input  logic              clk_apb,
   input  logic              rst_apb_n,
   input  logic [APB_AW-1:0] paddr,
   input  logic              pwrite,
   input  logic [31:0]       pwdata,
   input  logic              psel,
   input  logic              penable,
   output logic [31:0]       prdata,
   output logic              pready,
   output logic              pslverr,
   output logic              tx_req,
   output logic [31:0]       tx_id,
   output logic [63:0]       tx_data,
   output logic [3:0]        tx_dlc,
   output logic              tx_abort,
   input  logic              tx_done,
   input  logic              arb_lost,
   input  logic              tx_error,
   output logic              int_tx
);
   localparam int IW = (NUM_MB > 1) ? $clog2(NUM_MB) : 1;

   typedef enum logic [1:0] {IDLE, ARB, XFER} state_t;

   state_t            state_q, state_d;
   logic [IW-1:0]     act_q, act_d;
   logic              abort_q, abort_d;
   logic [NUM_MB-1:0] pend_q, pend_d;
   logic [NUM_MB-1:0] done_q, done_d;
   logic [NUM_MB-1:0] abrt_q, abrt_d;
   logic [1:0]        int_en_q, int_en_d;
   logic [31:0]       id_q    [NUM_MB];
   logic [31:0]       id_d    [NUM_MB];
   logic [63:0]       data_q  [NUM_MB];
   logic [63:0]       data_d  [NUM_MB];
   logic [3:0]        dlc_q   [NUM_MB];
   logic [3:0]        dlc_d   [NUM_MB];
   logic [3:0]        retry_q [NUM_MB];
   logic [3:0]        retry_d [NUM_MB];

   logic              acc, wr, rd, is_glb, is_mb, mapped, sel_pend;
   logic [IW-1:0]     mb_sel;
   logic [1:0]        fld;
   logic              is_cancel, wr_err, cancel_act, cancel_idle;
   logic [NUM_MB-1:0] cancel_msk, arb_pend;
   logic              win_found;
   logic [IW-1:0]     win_idx;
   logic [28:0]       win_id;

   always_comb begin
      acc       = psel & penable;
      wr        = acc & pwrite;
      rd        = psel & ~pwrite;
      fld       = paddr[3:2];
      mb_sel    = paddr[4 +: IW];
      is_glb    = (paddr[APB_AW-1:4] == '0) && (paddr[1:0] == 2'b00);
      is_mb     = (paddr[APB_AW-1:8] == (APB_AW-8)'(1)) && (paddr[1:0] == 2'b00) &&
                  (int'(paddr[7:4]) < NUM_MB);
      mapped    = is_glb | is_mb;
      sel_pend  = is_mb & pend_q[mb_sel];
      is_cancel = wr & is_mb & (fld == 2'd3) & pwdata[1];
      // A cancel of the in-flight frame must wait for the core's outcome pulse.
      cancel_act  = is_cancel & sel_pend & (state_q == XFER) & (mb_sel == act_q);
      cancel_idle = is_cancel & sel_pend & ~cancel_act;
      wr_err      = wr & sel_pend & ~((fld == 2'd3) & pwdata[1]);
      pslverr     = acc & (~mapped | wr_err);
      pready      = 1'b1;
      cancel_msk  = '0;
      if (cancel_idle) cancel_msk[mb_sel] = 1'b1;
      arb_pend  = pend_q & ~cancel_msk;
      win_found = 1'b0;
      win_idx   = '0;
      win_id    = '0;
      for (int i = 0; i < NUM_MB; i++) begin
         if (arb_pend[i] && (!win_found || (id_q[i][28:0] < win_id))) begin
            win_found = 1'b1;
            win_idx   = IW'(i);
            win_id    = id_q[i][28:0];
         end
      end
   end

   always_comb begin
      prdata = '0;
      if (rd && is_glb) begin
         case (fld)
            2'd0:    prdata = {8'd0, 4'(act_q), 3'd0, (state_q != IDLE), 16'(pend_q)};
            2'd1:    prdata = 32'(done_q);
            2'd2:    prdata = 32'(abrt_q);
            default: prdata = 32'(int_en_q);
         endcase
      end else if (rd && is_mb) begin
         case (fld)
            2'd0:    prdata = id_q[mb_sel];
            2'd1:    prdata = data_q[mb_sel][31:0];
            2'd2:    prdata = data_q[mb_sel][63:32];
            default: prdata = {24'd0, dlc_q[mb_sel], 3'd0, pend_q[mb_sel]};
         endcase
      end
   end

   always_comb begin
      state_d  = state_q;
      act_d    = act_q;
      abort_d  = 1'b0;
      pend_d   = pend_q;
      done_d   = done_q;
      abrt_d   = abrt_q;
      int_en_d = int_en_q;
      id_d     = id_q;
      data_d   = data_q;
      dlc_d    = dlc_q;
      retry_d  = retry_q;

      if (wr && is_glb) begin
         case (fld)
            2'd1:    done_d   = done_q & ~pwdata[NUM_MB-1:0];
            2'd2:    abrt_d   = abrt_q & ~pwdata[NUM_MB-1:0];
            2'd3:    int_en_d = pwdata[1:0];
            default: ;
         endcase
      end
      if (wr && is_mb && !sel_pend) begin
         case (fld)
            2'd0:    id_d[mb_sel]         = pwdata;
            2'd1:    data_d[mb_sel][31:0]  = pwdata;
            2'd2:    data_d[mb_sel][63:32] = pwdata;
            default: begin
               dlc_d[mb_sel] = pwdata[7:4];
               if (pwdata[0] && !pwdata[1]) pend_d[mb_sel] = 1'b1;
            end
         endcase
      end
      if (cancel_idle) begin
         pend_d[mb_sel]  = 1'b0;
         abrt_d[mb_sel]  = 1'b1;
         retry_d[mb_sel] = '0;
      end

      case (state_q)
         IDLE: if (|pend_q) state_d = ARB;
         ARB: begin
            if (win_found) begin
               act_d   = win_idx;
               state_d = XFER;
            end else begin
               state_d = IDLE;
            end
         end
         XFER: begin
            abort_d = abort_q | cancel_act;
            if (tx_done) begin
               pend_d[act_q]  = 1'b0;
               done_d[act_q]  = 1'b1;
               retry_d[act_q] = '0;
               abort_d        = 1'b0;
               state_d        = IDLE;
            end else if (arb_lost || tx_error) begin
               abort_d = 1'b0;
               state_d = IDLE;
               if (abort_q || cancel_act) begin
                  pend_d[act_q]  = 1'b0;
                  abrt_d[act_q]  = 1'b1;
                  retry_d[act_q] = '0;
               end else if (tx_error) begin
                  if (retry_q[act_q] + 4'd1 == 4'(RETRY_LIMIT)) begin
                     pend_d[act_q]  = 1'b0;
                     abrt_d[act_q]  = 1'b1;
                     retry_d[act_q] = '0;
                  end else begin
                     retry_d[act_q] = retry_q[act_q] + 4'd1;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_apb or negedge rst_apb_n) begin
      if (!rst_apb_n) begin
         state_q  <= IDLE;
         act_q    <= '0;
         abort_q  <= 1'b0;
         pend_q   <= '0;
         done_q   <= '0;
         abrt_q   <= '0;
         int_en_q <= '0;
         for (int i = 0; i < NUM_MB; i++) begin
            id_q[i]    <= '0;
            data_q[i]  <= '0;
            dlc_q[i]   <= '0;
            retry_q[i] <= '0;
         end
      end else begin
         state_q  <= state_d;
         act_q    <= act_d;
         abort_q  <= abort_d;
         pend_q   <= pend_d;
         done_q   <= done_d;
         abrt_q   <= abrt_d;
         int_en_q <= int_en_d;
         id_q     <= id_d;
         data_q   <= data_d;
         dlc_q    <= dlc_d;
         retry_q  <= retry_d;
      end
   end

   always_comb begin
      tx_req   = (state_q == XFER);
      tx_id    = tx_req ? id_q[act_q]   : '0;
      tx_data  = tx_req ? data_q[act_q] : '0;
      tx_dlc   = tx_req ? dlc_q[act_q]  : '0;
      tx_abort = abort_q;
      int_tx   = ((|done_q) & int_en_q[0]) | ((|abrt_q) & int_en_q[1]);
   end

endmodule

// File: tb/tb_can_tx_mailbox.sv
// Directed bench for can_tx_mailbox: APB driver, scoreboard of expected
// frame order, and a scripted protocol-core responder.
module tb_can_tx_mailbox;
   localparam int NUM_MB = 8;

   logic        clk_apb = 1'b0;
   logic        rst_apb_n = 1'b0;
   logic [11:0] paddr = '0;
   logic        pwrite = 1'b0;
   logic [31:0] pwdata = '0;
   logic        psel = 1'b0;
   logic        penable = 1'b0;
   logic [31:0] prdata;
   logic        pready, pslverr, tx_req, tx_abort, int_tx;
   logic [31:0] tx_id;
   logic [63:0] tx_data;
   logic [3:0]  tx_dlc;
   logic        tx_done = 1'b0, arb_lost = 1'b0, tx_error = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;
   int exp_q[$];
   logic [31:0] m_id   [NUM_MB];
   logic [63:0] m_data [NUM_MB];
   logic [3:0]  m_dlc  [NUM_MB];

   can_tx_mailbox #(.NUM_MB(NUM_MB), .RETRY_LIMIT(3), .APB_AW(12)) dut (
      .clk_apb(clk_apb), .rst_apb_n(rst_apb_n),
      .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata), .psel(psel), .penable(penable),
      .prdata(prdata), .pready(pready), .pslverr(pslverr),
      .tx_req(tx_req), .tx_id(tx_id), .tx_data(tx_data), .tx_dlc(tx_dlc),
      .tx_abort(tx_abort), .tx_done(tx_done), .arb_lost(arb_lost), .tx_error(tx_error),
      .int_tx(int_tx)
   );

   always #5 clk_apb = ~clk_apb;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic apb_write(input logic [11:0] a, input logic [31:0] d, output logic err);
      @(negedge clk_apb);
      paddr = a; pwdata = d; pwrite = 1'b1; psel = 1'b1; penable = 1'b0;
      @(negedge clk_apb);
      penable = 1'b1;
      #1 err = pslverr;
      @(negedge clk_apb);
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
   endtask

   task automatic apb_read(input logic [11:0] a, output logic [31:0] d, output logic err);
      @(negedge clk_apb);
      paddr = a; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
      @(negedge clk_apb);
      penable = 1'b1;
      #1 d = prdata; err = pslverr;
      check("pready", pready, 1'b1);
      @(negedge clk_apb);
      psel = 1'b0; penable = 1'b0;
   endtask

   task automatic set_mb(input int i, input logic [31:0] id, input logic [63:0] data,
                         input logic [3:0] dlc);
      logic e;
      apb_write(12'h100 + 12'(i * 16),       id,          e);
      apb_write(12'h100 + 12'(i * 16) + 12'h4, data[31:0],  e);
      apb_write(12'h100 + 12'(i * 16) + 12'h8, data[63:32], e);
      apb_write(12'h100 + 12'(i * 16) + 12'hC, {24'd0, dlc, 4'h0}, e);
      m_id[i] = id; m_data[i] = data; m_dlc[i] = dlc;
   endtask

   task automatic req_mb(input int i);
      logic e;
      apb_write(12'h100 + 12'(i * 16) + 12'hC, {24'd0, m_dlc[i], 4'h1}, e);
   endtask

   task automatic expect_frame(input string tag);
      bit seen;
      int idx;
      seen = 1'b0;
      for (int c = 0; c < 60 && !seen; c++) begin
         @(negedge clk_apb);
         seen = tx_req;
      end
      check({tag, "_req"}, seen, 1'b1);
      check({tag, "_sb"}, exp_q.size() != 0, 1'b1);
      if (seen && exp_q.size() != 0) begin
         idx = exp_q.pop_front();
         check({tag, "_id"},   tx_id,   m_id[idx]);
         check({tag, "_data"}, tx_data, m_data[idx]);
         check({tag, "_dlc"},  tx_dlc,  m_dlc[idx]);
      end
   endtask

   task automatic pulse(input logic d, input logic a, input logic e);
      @(negedge clk_apb);
      tx_done = d; arb_lost = a; tx_error = e;
      @(negedge clk_apb);
      tx_done = 1'b0; arb_lost = 1'b0; tx_error = 1'b0;
   endtask

   initial begin
      logic [31:0] rd;
      logic        err;

      repeat (3) @(negedge clk_apb);
      check("rst_tx_req", tx_req, 1'b0);
      check("rst_tx_abort", tx_abort, 1'b0);
      check("rst_tx_id", tx_id, 32'h0);
      check("rst_tx_data", tx_data, 64'h0);
      check("rst_int_tx", int_tx, 1'b0);
      check("rst_pready", pready, 1'b1);
      check("rst_prdata", prdata, 32'h0);
      check("rst_pslverr", pslverr, 1'b0);
      rst_apb_n = 1'b1;
      apb_read(12'h000, rd, err);
      check("rst_stat", rd, 32'h0);

      // Lowest ID wins: blocker mb7 holds the core while 0/1/2 queue up
      set_mb(7, 32'h7FF, 64'h7777_0000_7777_0000, 4'd2);
      req_mb(7); exp_q.push_back(7);
      expect_frame("blk7");
      set_mb(0, 32'h300, 64'hA0A0_0000_0000_0300, 4'd8);
      set_mb(1, 32'h100, 64'hA1A1_0000_0000_0100, 4'd8);
      set_mb(2, 32'h200, 64'hA2A2_0000_0000_0200, 4'd8);
      req_mb(0); req_mb(1); req_mb(2);
      exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(0);
      pulse(1'b1, 1'b0, 1'b0);
      apb_write(12'h004, 32'h80, err);
      for (int k = 0; k < 3; k++) begin
         expect_frame("order");
         pulse(1'b1, 1'b0, 1'b0);
      end
      apb_read(12'h004, rd, err);
      check("done_order", rd, 32'h7);
      check("int_disabled", int_tx, 1'b0);

      // Equal IDs: lower index first, STAT shows active index 3
      set_mb(3, 32'h050, 64'h3333_3333_3333_3333, 4'd4);
      set_mb(5, 32'h050, 64'h5555_5555_5555_5555, 4'd5);
      req_mb(7); exp_q.push_back(7);
      expect_frame("blk7b");
      req_mb(3); req_mb(5);
      exp_q.push_back(3); exp_q.push_back(5);
      pulse(1'b1, 1'b0, 1'b0);
      expect_frame("tie3");
      apb_read(12'h000, rd, err);
      check("stat_tie3", rd, 32'h0031_0028);
      pulse(1'b1, 1'b0, 1'b0);
      expect_frame("tie5");
      pulse(1'b1, 1'b0, 1'b0);
      apb_write(12'h004, 32'hFF, err);
      apb_read(12'h004, rd, err);
      check("done_w1c", rd, 32'h0);

      // Retry limit on mailbox 0
      apb_write(12'h00C, 32'h2, err);
      req_mb(0); exp_q.push_back(0);
      expect_frame("err1");
      pulse(1'b0, 1'b0, 1'b1);
      exp_q.push_back(0);
      apb_read(12'h000, rd, err);
      check("err1_pend", rd[15:0], 16'h0001);
      expect_frame("err2");
      pulse(1'b0, 1'b0, 1'b1);
      exp_q.push_back(0);
      expect_frame("err3");
      pulse(1'b0, 1'b0, 1'b1);
      apb_read(12'h008, rd, err);
      check("abrt_retry", rd, 32'h1);
      apb_read(12'h000, rd, err);
      check("retry_pend", rd[15:0], 16'h0);
      check("retry_no_req", tx_req, 1'b0);
      check("int_abort", int_tx, 1'b1);
      apb_write(12'h008, 32'h1, err);
      check("int_cleared", int_tx, 1'b0);

      // Arbitration loss keeps pending; cancel then loss aborts
      req_mb(2); exp_q.push_back(2);
      expect_frame("al1");
      pulse(1'b0, 1'b1, 1'b0);
      exp_q.push_back(2);
      apb_read(12'h000, rd, err);
      check("al_pend", rd[15:0], 16'h0004);
      expect_frame("al2");
      apb_write(12'h12C, {24'd0, m_dlc[2], 4'h2}, err);
      check("al_tx_abort", tx_abort, 1'b1);
      check("al_still_req", tx_req, 1'b1);
      pulse(1'b0, 1'b1, 1'b0);
      apb_read(12'h008, rd, err);
      check("al_aborted", rd, 32'h4);
      apb_read(12'h000, rd, err);
      check("al_pend_clr", rd[15:0], 16'h0);
      check("al_abort_drop", tx_abort, 1'b0);
      apb_write(12'h008, 32'h4, err);

      // Pending-mailbox write protection and unmapped addresses
      set_mb(4, 32'h444, 64'h2222_2222_1111_1111, 4'd8);
      req_mb(4); exp_q.push_back(4);
      apb_write(12'h144, 32'hDEAD_BEEF, err);
      check("wr_pend_err", err, 1'b1);
      apb_write(12'h140, 32'h0000_0001, err);
      check("wr_pend_id_err", err, 1'b1);
      apb_read(12'h144, rd, err);
      check("wr_pend_data", rd, 32'h1111_1111);
      check("rd_pend_err", err, 1'b0);
      apb_read(12'h3F0, rd, err);
      check("unmap_data", rd, 32'h0);
      check("unmap_err", err, 1'b1);
      apb_read(12'h180, rd, err);
      check("bad_mb_data", rd, 32'h0);
      check("bad_mb_err", err, 1'b1);
      expect_frame("prot4");
      pulse(1'b1, 1'b0, 1'b0);
      apb_write(12'h004, 32'h10, err);

      // REQ together with CANCEL on an idle mailbox does nothing
      apb_write(12'h15C, 32'h83, err);
      apb_read(12'h000, rd, err);
      check("reqcancel_pend", rd[15:0], 16'h0);

      // Cancel in the same cycle as tx_done resolves to DONE
      set_mb(6, 32'h066, 64'h6666_0000_6666_0000, 4'd6);
      req_mb(6); exp_q.push_back(6);
      expect_frame("race6");
      @(negedge clk_apb);
      paddr = 12'h16C; pwdata = {24'd0, 4'd6, 4'h2}; pwrite = 1'b1; psel = 1'b1; penable = 1'b0;
      @(negedge clk_apb);
      penable = 1'b1; tx_done = 1'b1;
      @(negedge clk_apb);
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0; tx_done = 1'b0;
      apb_read(12'h004, rd, err);
      check("race_done", rd, 32'h40);
      apb_read(12'h008, rd, err);
      check("race_abrt", rd, 32'h0);
      apb_write(12'h004, 32'h40, err);

      // Outcome pulses while idle are ignored
      pulse(1'b1, 1'b1, 1'b1);
      apb_read(12'h004, rd, err);
      check("idle_done", rd, 32'h0);
      apb_read(12'h008, rd, err);
      check("idle_abrt", rd, 32'h0);

      // Reset in the middle of a transfer
      req_mb(1); exp_q.push_back(1);
      expect_frame("rst1");
      @(negedge clk_apb);
      rst_apb_n = 1'b0;
      #1;
      check("midrst_req", tx_req, 1'b0);
      check("midrst_id", tx_id, 32'h0);
      @(negedge clk_apb);
      rst_apb_n = 1'b1;
      apb_read(12'h004, rd, err);
      check("midrst_done", rd, 32'h0);
      apb_read(12'h008, rd, err);
      check("midrst_abrt", rd, 32'h0);
      apb_read(12'h000, rd, err);
      check("midrst_stat", rd, 32'h0);
      apb_read(12'h110, rd, err);
      check("midrst_mbid", rd, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
